// File: rtl/get_param_if.sv
// Parameter-generator bus: control inputs, child-set pushes and the issued parameter set.
interface get_param_if #(
    parameter int unsigned I_W   = 8,
    parameter int unsigned Z_W   = 4,
    parameter int unsigned KL_W  = 16,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned D_W = $clog2(DEPTH) + 1;

    logic            start;
    logic [I_W-1:0]  init_i;
    logic [Z_W-1:0]  init_z;
    logic [KL_W-1:0] init_k;
    logic [KL_W-1:0] init_l;
    logic            push_valid;
    logic [I_W-1:0]  push_i;
    logic [Z_W-1:0]  push_z;
    logic [KL_W-1:0] push_k;
    logic [KL_W-1:0] push_l;
    logic            step_done;
    logic [I_W-1:0]  param_i;
    logic [Z_W-1:0]  param_z;
    logic [KL_W-1:0] param_k;
    logic [KL_W-1:0] param_l;
    logic [2:0]      en_get_param;
    logic            busy;
    logic            ovf;
    logic [D_W-1:0]  depth;

    modport master (
        output start, init_i, init_z, init_k, init_l,
        output push_valid, push_i, push_z, push_k, push_l, step_done,
        input  param_i, param_z, param_k, param_l, en_get_param, busy, ovf, depth
    );

    modport slave (
        input  start, init_i, init_z, init_k, init_l,
        input  push_valid, push_i, push_z, push_k, push_l, step_done,
        output param_i, param_z, param_k, param_l, en_get_param, busy, ovf, depth
    );
endinterface

// File: rtl/get_param.sv
// LIFO-driven generator of (i, z, k, l) search parameter sets for get_data.
module get_param #(
    parameter int unsigned I_W   = 8,
    parameter int unsigned Z_W   = 4,
    parameter int unsigned KL_W  = 16,
    parameter int unsigned DEPTH = 16
) (
    input logic        clk,
    input logic        rst_n,
    get_param_if.slave bus
);
    localparam int unsigned P_W = I_W + Z_W + 2 * KL_W;
    localparam int unsigned A_W = $clog2(DEPTH);
    localparam int unsigned D_W = A_W + 1;

    localparam logic [2:0] EN_NONE = 3'b000;
    localparam logic [2:0] EN_NEW  = 3'b001;
    localparam logic [2:0] EN_DONE = 3'b010;
    localparam logic [2:0] EN_OVF  = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t          state_q;
    state_t          state_d;
    logic [D_W-1:0]  depth_q;
    logic [P_W-1:0]  param_q;
    logic [2:0]      en_q;
    logic [2:0]      en_d;
    logic            ovf_q;
    logic            busy_q;
    logic [P_W-1:0]  mem [DEPTH];

    logic            do_push;
    logic            do_pop;
    logic            set_ovf;
    logic            clr_ovf;
    logic            full;
    logic            empty;
    logic [P_W-1:0]  push_data;
    logic [A_W-1:0]  top_idx;

    assign full    = (depth_q == D_W'(DEPTH));
    assign empty   = (depth_q == '0);
    assign top_idx = A_W'(depth_q - D_W'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state, stack commands and next command code.
    // A push arriving in ISSUE is taken first and the pop deferred a cycle, so
    // the newest child is still the one popped and an overflow pulse never
    // collides with the new-set pulse.
    always_comb begin
        state_d   = state_q;
        en_d      = EN_NONE;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        set_ovf   = 1'b0;
        clr_ovf   = 1'b0;
        push_data = {bus.push_i, bus.push_z, bus.push_k, bus.push_l};
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    do_push   = 1'b1;
                    clr_ovf   = 1'b1;
                    push_data = {bus.init_i, bus.init_z, bus.init_k, bus.init_l};
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.push_valid) begin
                    if (full) begin
                        set_ovf = 1'b1;
                        en_d    = EN_OVF;
                    end else begin
                        do_push = 1'b1;
                    end
                end else if (!empty) begin
                    do_pop  = 1'b1;
                    en_d    = EN_NEW;
                    state_d = S_WAIT;
                end else begin
                    en_d    = EN_DONE;
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                if (bus.push_valid) begin
                    if (full) begin
                        set_ovf = 1'b1;
                        en_d    = EN_OVF;
                    end else begin
                        do_push = 1'b1;
                    end
                end
                if (bus.step_done) state_d = S_ISSUE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Occupancy, issued set and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
            param_q <= '0;
            en_q    <= EN_NONE;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            en_q   <= en_d;
            busy_q <= (state_d != S_IDLE);
            if (do_push)     depth_q <= depth_q + D_W'(1);
            else if (do_pop) depth_q <= depth_q - D_W'(1);
            if (do_pop)      param_q <= mem[top_idx];
            if (clr_ovf)     ovf_q   <= 1'b0;
            else if (set_ovf) ovf_q  <= 1'b1;
        end
    end

    // Stack storage; stale entries above depth are never read.
    always_ff @(posedge clk) begin
        if (do_push) mem[depth_q[A_W-1:0]] <= push_data;
    end

    assign bus.param_i      = param_q[P_W-1 -: I_W];
    assign bus.param_z      = param_q[2*KL_W +: Z_W];
    assign bus.param_k      = param_q[KL_W +: KL_W];
    assign bus.param_l      = param_q[0 +: KL_W];
    assign bus.en_get_param = en_q;
    assign bus.busy         = busy_q;
    assign bus.ovf          = ovf_q;
    assign bus.depth        = depth_q;
endmodule

// File: tb/tb_get_param.sv
// Directed bench for get_param: cycle table plus overflow and reset sequences.
module tb_get_param;
    logic clk;
    logic rst_n;

    get_param_if #(.I_W(8), .Z_W(4), .KL_W(16), .DEPTH(16)) bus ();

    get_param #(.I_W(8), .Z_W(4), .KL_W(16), .DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [43:0] init;
        logic        pv;
        logic [43:0] push;
        logic        sd;
        logic [2:0]  en;
        logic [43:0] par;
        logic [4:0]  dep;
        logic        busy;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;
    int n_ovf_pulse = 0;
    vec_t tbl [24];

    function automatic logic [43:0] P(int i, int z, int k, int l);
        return {8'(i), 4'(z), 16'(k), 16'(l)};
    endfunction

    function automatic vec_t V(logic st, logic [43:0] ini, logic pv, logic [43:0] psh, logic sd,
                               logic [2:0] en, logic [43:0] par, int dep, logic busy);
        vec_t v;
        v.start = st; v.init = ini; v.pv = pv; v.push = psh; v.sd = sd;
        v.en = en; v.par = par; v.dep = 5'(dep); v.busy = busy;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(logic st, logic [43:0] ini, logic pv, logic [43:0] psh, logic sd);
        bus.start = st;
        {bus.init_i, bus.init_z, bus.init_k, bus.init_l} = ini;
        bus.push_valid = pv;
        {bus.push_i, bus.push_z, bus.push_k, bus.push_l} = psh;
        bus.step_done = sd;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (bus.en_get_param == 3'b100) n_ovf_pulse++;
    endtask

    function automatic logic [43:0] par_out();
        return {bus.param_i, bus.param_z, bus.param_k, bus.param_l};
    endfunction

    task automatic chk_all(string tag, logic [2:0] en, logic [43:0] par, int dep, logic busy, logic ovf);
        chk({tag, ".en"},    64'(bus.en_get_param), 64'(en));
        chk({tag, ".param"}, 64'(par_out()),        64'(par));
        chk({tag, ".depth"}, 64'(bus.depth),        64'(dep));
        chk({tag, ".busy"},  64'(bus.busy),         64'(busy));
        chk({tag, ".ovf"},   64'(bus.ovf),          64'(ovf));
    endtask

    initial begin
        logic [43:0] x0, x, a, b, c, y, j1, j2, ini, e;

        x0 = P(20, 2, 0, 999); x = P(30, 3, 1, 100);
        a  = P(19, 2, 5, 9);   b = P(19, 1, 7, 8);
        c  = P(3, 0, 1, 1);    y = P(50, 1, 2, 3);
        j1 = P(99, 9, 9, 9);   j2 = P(77, 7, 7, 7);

        // Inputs applied in a cycle, expected outputs after that cycle's edge.
        tbl[0]  = V(1, x0, 0, 0, 0, 3'b000, 0,  1, 1);
        tbl[1]  = V(0, 0,  0, 0, 0, 3'b001, x0, 0, 1);
        tbl[2]  = V(0, 0,  0, 0, 1, 3'b000, x0, 0, 1);
        tbl[3]  = V(0, 0,  0, 0, 0, 3'b010, x0, 0, 1);
        tbl[4]  = V(0, 0,  0, 0, 0, 3'b000, x0, 0, 0);
        tbl[5]  = V(1, x,  0, 0, 0, 3'b000, x0, 1, 1);
        tbl[6]  = V(0, 0,  0, 0, 0, 3'b001, x,  0, 1);
        tbl[7]  = V(0, 0,  1, a, 0, 3'b000, x,  1, 1);
        tbl[8]  = V(0, 0,  1, b, 0, 3'b000, x,  2, 1);
        tbl[9]  = V(0, 0,  0, 0, 1, 3'b000, x,  2, 1);
        tbl[10] = V(0, 0,  0, 0, 0, 3'b001, b,  1, 1);
        tbl[11] = V(0, 0,  0, 0, 1, 3'b000, b,  1, 1);
        tbl[12] = V(0, 0,  0, 0, 0, 3'b001, a,  0, 1);
        tbl[13] = V(0, 0,  1, c, 1, 3'b000, a,  1, 1);
        tbl[14] = V(0, 0,  0, 0, 0, 3'b001, c,  0, 1);
        tbl[15] = V(0, 0,  0, 0, 1, 3'b000, c,  0, 1);
        tbl[16] = V(0, 0,  0, 0, 0, 3'b010, c,  0, 1);
        tbl[17] = V(0, 0,  0, 0, 0, 3'b000, c,  0, 0);
        tbl[18] = V(1, y,  0, 0, 0, 3'b000, c,  1, 1);
        tbl[19] = V(1, j1, 0, 0, 0, 3'b001, y,  0, 1);
        tbl[20] = V(1, j2, 0, 0, 0, 3'b000, y,  0, 1);
        tbl[21] = V(1, j2, 0, 0, 1, 3'b000, y,  0, 1);
        tbl[22] = V(0, 0,  0, 0, 0, 3'b010, y,  0, 1);
        tbl[23] = V(0, 0,  0, 0, 0, 3'b000, y,  0, 0);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk_all("reset", 3'b000, 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].start, tbl[i].init, tbl[i].pv, tbl[i].push, tbl[i].sd);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].en, tbl[i].par, tbl[i].dep, tbl[i].busy, 1'b0);
        end

        // Overflow: 17 pushes into a 16-deep stack.
        ini = P(1, 1, 1, 1);
        n_ovf_pulse = 0;
        drive(1, ini, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0);   step();
        chk_all("ovf.first", 3'b001, ini, 0, 1, 0);
        for (int n = 0; n < 17; n++) begin
            drive(0, 0, 1, P(n, n, 1000 + n, 2000 + n), 0);
            step();
            if (n < 16) chk_all($sformatf("ovf.push%0d", n), 3'b000, ini, n + 1, 1, 0);
            else        chk_all("ovf.drop", 3'b100, ini, 16, 1, 1);
        end
        drive(0, 0, 0, 0, 0); step();
        chk_all("ovf.after", 3'b000, ini, 16, 1, 1);
        for (int n = 15; n >= 0; n--) begin
            e = P(n, n, 1000 + n, 2000 + n);
            drive(0, 0, 0, 0, 1); step();
            drive(0, 0, 0, 0, 0); step();
            chk_all($sformatf("ovf.pop%0d", n), 3'b001, e, n, 1, 1);
        end
        e = P(0, 0, 1000, 2000);
        drive(0, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0); step();
        chk_all("ovf.done", 3'b010, e, 0, 1, 1);
        step();
        chk_all("ovf.idle", 3'b000, e, 0, 0, 1);
        chk("ovf.pulse_count", 64'(n_ovf_pulse), 64'd1);

        // New start clears ovf; then reset in WAIT with depth 5.
        ini = P(8, 4, 40, 400);
        drive(1, ini, 0, 0, 0); step();
        chk_all("rst.start", 3'b000, e, 1, 1, 0);
        drive(0, 0, 0, 0, 0); step();
        chk_all("rst.first", 3'b001, ini, 0, 1, 0);
        for (int n = 0; n < 5; n++) begin
            drive(0, 0, 1, P(n + 1, 1, n, n), 0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        chk_all("rst.pre", 3'b000, ini, 5, 1, 0);
        #2 rst_n = 1'b0;
        #1 chk_all("rst.async", 3'b000, 0, 0, 0, 0);
        @(negedge clk);
        chk_all("rst.held", 3'b000, 0, 0, 0, 0);
        rst_n = 1'b1;
        ini = P(200, 15, 65535, 12345);
        drive(1, ini, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0); step();
        chk_all("rst.restart", 3'b001, ini, 0, 1, 0);
        drive(0, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0); step();
        chk_all("rst.done", 3'b010, ini, 0, 1, 0);
        step();
        chk_all("rst.idle", 3'b000, ini, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
